mmio_ram_arbiter: RTL and testbench
===================================

// Module: mmio_ram_arbiter
// PURPOSE
//  Successor to the CPU-side address unit. It sits between the pipeline's IF/MEM stages and the single-port SRAM.
//  - Translates kseg addresses to SRAM word addresses.
//  - Decodes a parametrised MMIO window holding one LED register and NUM_DPY display registers.
//  - Serialises same-cycle instruction and data SRAM accesses with a two-state arbiter that stalls the pipeline.
// PARAMETERS
//  DATA_W    32            data bus width
//  RAM_AW    20            SRAM word-address width; taken from addr[RAM_AW+1:2]
//  LED_W     16            LED register width (LED_W <= DATA_W)
//  NUM_DPY   2             number of 8-bit display registers (1..8)
//  MMIO_BASE 32'hBFD00400  LED address; display k is at MMIO_BASE+8+4*k
// PORTS
//  clk          in   1              system clock, rising edge
//  rst_n        in   1              asynchronous active-low reset
//  inst_req_i   in   1              IF stage requests a fetch this cycle
//  inst_addr_i  in   32             fetch virtual address
//  data_addr_i  in   32             MEM-stage virtual address
//  ram_op_i     in   4              MEM op; MEM_NOP means no data access
//  store_data_i in   DATA_W         store data
//  sram_rdata_i in   DATA_W         SRAM read data, valid in the same cycle
//  sram_addr_o  out  RAM_AW         SRAM word address
//  sram_op_o    out  4              SRAM op; MEM_NOP when SRAM is idle
//  sram_wdata_o out  DATA_W         SRAM write data
//  load_data_o  out  DATA_W         data returned to the MEM stage
//  load_inst_o  out  DATA_W         instruction returned to the IF stage
//  stall_o      out  1              pipeline hold request
//  led_o        out  LED_W          LED register
//  dpy_o        out  8*NUM_DPY      display registers; display k at [8k+7:8k]
// BEHAVIOUR
//  - Reset (async, rst_n=0): led_o=0, every dpy byte=0, state=IDLE, stall_o=0.
//    Combinational outputs follow the IDLE rules.
//  - mmio_hit = (ram_op_i!=MEM_NOP) && data_addr_i in [MMIO_BASE, MMIO_BASE+8+4*NUM_DPY).
//    An MMIO hit never touches SRAM: sram_op_o=MEM_NOP for the data side.
//  - MMIO writes happen at the rising edge of the cycle the store is presented.
//    - LED write: led_o <= store_data_i[LED_W-1:0].
//    - Display k write: byte k <= store_data_i[7:0].
//    - Byte and half-word stores write the same low bits.
//    - Writes to unmapped in-window offsets (e.g. BASE+4) are ignored.
//  - MMIO reads are combinational, zero-extended into load_data_o. Unmapped offsets read 0.
//  - FSM IDLE:
//    - Data SRAM access with inst_req_i=0: serve data; load_inst_o=0.
//    - inst_req_i=1 with no data SRAM access: serve fetch; load_inst_o=sram_rdata_i.
//    - Both present (conflict): serve data first, stall_o=1, go to INST.
//  - FSM INST:
//    - Serve the fetch using the held inst_addr_i; stall_o=0; return to IDLE.
//    - Data side is MEM_NOP to SRAM.
//    - load_data_o carries the data word captured in the previous cycle, so a load completes across the stall.
//  - The CPU holds all inputs while stall_o=1. A store is therefore issued to SRAM exactly once.
//  - A conflict plus an MMIO hit is not a conflict: no stall.
//  - Reset during INST returns the FSM to IDLE. The pending fetch is dropped; the CPU refetches after reset.
//  - Addresses are not range-checked beyond the MMIO window; upper bits above RAM_AW+1 are discarded.
// CONFIGURATION
//  - MMIO_DPY_SEG_EN defined: each display register holds a hex digit in [3:0].
//    - dpy_o byte k = seven-segment code {dp=0, g..a} of that digit.
//    - Reads return the stored digit, not the segment code.
//  - MMIO_DPY_SEG_EN undefined: dpy_o bytes are raw register contents; no decoder is instantiated.
// STRUCTURE
//  - Shared package/defines: MEM_* op encodings, MMIO offset constants (LED_OFS=0, DPY_OFS=8, DPY_STRIDE=4), FSM state encodings.
//  - One sub-module, hex_to_seg7 (4-bit digit -> 8-bit segment code), instanced NUM_DPY times under MMIO_DPY_SEG_EN.
// TESTING
//  1. Hold rst_n=0 with a store pending, release -> led_o=0, dpy_o=0, stall_o=0; no SRAM write in reset.
//  2. SW 0x0000A5A5 to 0xBFD00400 -> next edge led_o=16'hA5A5; sram_op_o=MEM_NOP; load from same address returns 0x0000A5A5.
//  3. Store 0x3C to 0xBFD0040C (display 1) -> dpy_o[15:8]=8'h3C, or seg(0xC) when MMIO_DPY_SEG_EN is set; store to 0xBFD00404 changes nothing.
//  4. inst_req_i=1 @0x80000000 with LW @0x80100010 -> cycle1: sram_addr_o=0x40004, stall_o=1; cycle2: sram_addr_o=0, stall_o=0, load_inst_o=SRAM word 0, load_data_o holds the cycle-1 word.
//  5. Conflict with SW: data written once in cycle 1; no SRAM write in cycle 2.
//  6. Drop rst_n in INST state -> FSM IDLE, stall_o=0 immediately (async).

Source files
------------

// File: rtl/mmio_ram_arbiter_pkg.sv
// ============================================================================
// Module  : mmio_ram_arbiter_pkg
// Brief   : Shared memory-op encodings, MMIO offsets and arbiter state codes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mmio_ram_arbiter_pkg;

    localparam logic [3:0] MEM_NOP = 4'h0;
    localparam logic [3:0] MEM_LB  = 4'h1;
    localparam logic [3:0] MEM_LBU = 4'h2;
    localparam logic [3:0] MEM_LH  = 4'h3;
    localparam logic [3:0] MEM_LHU = 4'h4;
    localparam logic [3:0] MEM_LW  = 4'h5;
    localparam logic [3:0] MEM_SB  = 4'h6;
    localparam logic [3:0] MEM_SH  = 4'h7;
    localparam logic [3:0] MEM_SW  = 4'h8;

    localparam int unsigned LED_OFS    = 0;
    localparam int unsigned DPY_OFS    = 8;
    localparam int unsigned DPY_STRIDE = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_INST = 1'b1
    } arb_state_e;

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_ram_arbiter_hex_to_seg7.sv
// ============================================================================
// Module  : hex_to_seg7
// Brief   : Hex digit to active-high seven-segment code {dp=0, g..a}.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_to_seg7 (
    input  logic [3:0] digit_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = 8'h00;
        case (digit_i)
            4'h0: seg_o = 8'h3F;
            4'h1: seg_o = 8'h06;
            4'h2: seg_o = 8'h5B;
            4'h3: seg_o = 8'h4F;
            4'h4: seg_o = 8'h66;
            4'h5: seg_o = 8'h6D;
            4'h6: seg_o = 8'h7D;
            4'h7: seg_o = 8'h07;
            4'h8: seg_o = 8'h7F;
            4'h9: seg_o = 8'h6F;
            4'hA: seg_o = 8'h77;
            4'hB: seg_o = 8'h7C;
            4'hC: seg_o = 8'h39;
            4'hD: seg_o = 8'h5E;
            4'hE: seg_o = 8'h79;
            4'hF: seg_o = 8'h71;
            default: seg_o = 8'h00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mmio_ram_arbiter.sv
// ============================================================================
// Module  : mmio_ram_arbiter
// Brief   : kseg->SRAM translation, LED/display MMIO window and IF/MEM
//           SRAM arbiter. Define MMIO_DPY_SEG_EN for seven-segment display out.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_ram_arbiter
    import mmio_ram_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RAM_AW    = 20,
    parameter int unsigned LED_W     = 16,
    parameter int unsigned NUM_DPY   = 2,
    parameter logic [31:0] MMIO_BASE = 32'hBFD00400
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inst_req_i,
    input  logic [31:0]          inst_addr_i,
    input  logic [31:0]          data_addr_i,
    input  logic [3:0]           ram_op_i,
    input  logic [DATA_W-1:0]    store_data_i,
    input  logic [DATA_W-1:0]    sram_rdata_i,
    output logic [RAM_AW-1:0]    sram_addr_o,
    output logic [3:0]           sram_op_o,
    output logic [DATA_W-1:0]    sram_wdata_o,
    output logic [DATA_W-1:0]    load_data_o,
    output logic [DATA_W-1:0]    load_inst_o,
    output logic                 stall_o,
    output logic [LED_W-1:0]     led_o,
    output logic [8*NUM_DPY-1:0] dpy_o
);

    localparam logic [31:0] WIN_SIZE = 32'(DPY_OFS + DPY_STRIDE * NUM_DPY);

    arb_state_e                   state_q, state_d;
    logic [LED_W-1:0]             led_q, led_d;
    logic [NUM_DPY-1:0][7:0]      dpy_q, dpy_d;
    logic [DATA_W-1:0]            hold_q, hold_d;

    logic [31:0]                  w_ofs;
    logic [3:0]                   w_word;
    logic                         w_mmio_hit;
    logic                         w_data_ram;
    logic [7:0]                   w_dpy_wval;
    logic [DATA_W-1:0]            w_mmio_rd;
    logic                         w_unused;

    // Below-base addresses wrap to huge offsets, so one compare bounds both ends.
    assign w_ofs      = data_addr_i - MMIO_BASE;
    assign w_word     = w_ofs[5:2];
    assign w_mmio_hit = (ram_op_i != MEM_NOP) && (w_ofs < WIN_SIZE);
    assign w_data_ram = (ram_op_i != MEM_NOP) && !w_mmio_hit;
    assign w_unused   = &{1'b0, inst_addr_i, w_ofs[1:0]};

`ifdef MMIO_DPY_SEG_EN
    assign w_dpy_wval = {4'h0, store_data_i[3:0]};
`else
    assign w_dpy_wval = store_data_i[7:0];
`endif

    always_comb begin
        led_d     = led_q;
        dpy_d     = dpy_q;
        w_mmio_rd = '0;
        if (w_word == 4'(LED_OFS / 4)) begin
            w_mmio_rd = DATA_W'(led_q);
            if (w_mmio_hit && is_store(ram_op_i)) led_d = store_data_i[LED_W-1:0];
        end
        for (int k = 0; k < int'(NUM_DPY); k++) begin
            if (w_word == 4'((DPY_OFS + DPY_STRIDE * k) / 4)) begin
                w_mmio_rd = DATA_W'(dpy_q[k]);
                if (w_mmio_hit && is_store(ram_op_i)) dpy_d[k] = w_dpy_wval;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        stall_o      = 1'b0;
        sram_addr_o  = '0;
        sram_op_o    = MEM_NOP;
        sram_wdata_o = '0;
        load_inst_o  = '0;
        load_data_o  = w_mmio_hit ? w_mmio_rd : '0;
        case (state_q)
            ST_IDLE: begin
                if (w_data_ram) begin
                    sram_addr_o  = data_addr_i[RAM_AW+1:2];
                    sram_op_o    = ram_op_i;
                    sram_wdata_o = store_data_i;
                    load_data_o  = sram_rdata_i;
                    if (inst_req_i) begin
                        stall_o = 1'b1;
                        hold_d  = sram_rdata_i;
                        state_d = ST_INST;
                    end
                end else if (inst_req_i) begin
                    sram_addr_o = inst_addr_i[RAM_AW+1:2];
                    sram_op_o   = MEM_LW;
                    load_inst_o = sram_rdata_i;
                end
            end
            ST_INST: begin
                sram_addr_o = inst_addr_i[RAM_AW+1:2];
                sram_op_o   = MEM_LW;
                load_inst_o = sram_rdata_i;
                load_data_o = hold_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Keep SRAM and pipeline quiet while reset is asserted, even with a store pending.
        if (!rst_n) begin
            sram_op_o = MEM_NOP;
            stall_o   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            led_q   <= '0;
            dpy_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            dpy_q   <= dpy_d;
            hold_q  <= hold_d;
        end
    end

    assign led_o = led_q;

`ifdef MMIO_DPY_SEG_EN
    for (genvar k = 0; k < int'(NUM_DPY); k++) begin : g_seg
        hex_to_seg7 u_seg (
            .digit_i (dpy_q[k][3:0]),
            .seg_o   (dpy_o[8*k +: 8])
        );
    end
`else
    assign dpy_o = dpy_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mmio_ram_arbiter.sv
// ============================================================================
// Module  : tb_mmio_ram_arbiter
// Brief   : Scoreboard bench for mmio_ram_arbiter with directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_ram_arbiter;
    import mmio_ram_arbiter_pkg::*;

    localparam int F_ADDR = 0, F_OP = 1, F_LDATA = 2, F_LINST = 3, F_STALL = 4;
    localparam int F_LED = 5, F_DPY = 6, F_WCNT = 7, F_WDATA = 8;

    typedef struct {
        string       name;
        int          fld;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_req;
    logic [31:0] inst_addr, data_addr, store_data, sram_rdata;
    logic [3:0]  ram_op;
    logic [19:0] sram_addr;
    logic [3:0]  sram_op;
    logic [31:0] sram_wdata, load_data, load_inst;
    logic        stall;
    logic [15:0] led;
    logic [15:0] dpy;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   wcount   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [19:0] a);
        return {12'hC0D, a};
    endfunction

    assign sram_rdata = ram_word(sram_addr);

    mmio_ram_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst_req_i   (inst_req),
        .inst_addr_i  (inst_addr),
        .data_addr_i  (data_addr),
        .ram_op_i     (ram_op),
        .store_data_i (store_data),
        .sram_rdata_i (sram_rdata),
        .sram_addr_o  (sram_addr),
        .sram_op_o    (sram_op),
        .sram_wdata_o (sram_wdata),
        .load_data_o  (load_data),
        .load_inst_o  (load_inst),
        .stall_o      (stall),
        .led_o        (led),
        .dpy_o        (dpy)
    );

    always @(posedge clk)
        if (sram_op == MEM_SB || sram_op == MEM_SH || sram_op == MEM_SW) wcount <= wcount + 1;

    function automatic logic [31:0] actual(input int f);
        case (f)
            F_ADDR:  return {12'h0, sram_addr};
            F_OP:    return {28'h0, sram_op};
            F_LDATA: return load_data;
            F_LINST: return load_inst;
            F_STALL: return {31'h0, stall};
            F_LED:   return {16'h0, led};
            F_DPY:   return {16'h0, dpy};
            F_WCNT:  return wcount;
            F_WDATA: return sram_wdata;
            default: return 32'hDEAD_DEAD;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic [31:0] a;
        while (q.size() > 0) begin
            e = q.pop_front();
            a = actual(e.fld);
            checks++;
            if (a !== e.exp) begin
                failures++;
                $display("FAIL %s actual=%h expected=%h", e.name, a, e.exp);
            end
        end
    end

    task automatic expect_v(input string n, input int f, input logic [31:0] v);
        q.push_back('{n, f, v});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic [3:0] op,
                         input logic [31:0] da, input logic [31:0] sd);
        inst_req = ir; inst_addr = ia; ram_op = op; data_addr = da; store_data = sd;
    endtask

`ifdef MMIO_DPY_SEG_EN
    localparam logic [7:0]  DPY1_OUT = 8'h39;
    localparam logic [31:0] DPY1_RD  = 32'h0000000C;
`else
    localparam logic [7:0]  DPY1_OUT = 8'h3C;
    localparam logic [31:0] DPY1_RD  = 32'h0000003C;
`endif

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'h0, MEM_SW, 32'h8000_0040, 32'h1234_5678);
        // reset held with a store pending
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_v("rst_stall", F_STALL, 32'h0);
            expect_v("rst_sram_op", F_OP, {28'h0, MEM_NOP});
            expect_v("rst_led", F_LED, 32'h0);
            expect_v("rst_dpy", F_DPY, 32'h0);
        end
        drive(1'b0, 32'h0, MEM_NOP, 32'h0, 32'h0);
        #2 rst_n = 1'b1;
        tick();
        expect_v("rst_no_write", F_WCNT, 32'd0);

        // LED store then load back
        drive(1'b0, 32'h0, MEM_SW, 32'hBFD0_0400, 32'h0000_A5A5);
        expect_v("led_st_op", F_OP, {28'h0, MEM_NOP});
        expect_v("led_st_stall", F_STALL, 32'h0);
        tick();
        drive(1'b0, 32'h0, MEM_LW, 32'hBFD0_0400, 32'h0);
        expect_v("led_val", F_LED, 32'h0000_A5A5);
        expect_v("led_ld", F_LDATA, 32'h0000_A5A5);
        expect_v("led_ld_op", F_OP, {28'h0, MEM_NOP});

        // display 1 store, then unmapped in-window store
        tick();
        drive(1'b0, 32'h0, MEM_SB, 32'hBFD0_040C, 32'h0000_003C);
        tick();
        drive(1'b0, 32'h0, MEM_SW, 32'hBFD0_0404, 32'hFFFF_FFFF);
        expect_v("dpy1", F_DPY, {16'h0, DPY1_OUT, 8'h00});
        tick();
        drive(1'b0, 32'h0, MEM_LW, 32'hBFD0_040C, 32'h0);
        expect_v("dpy_unmapped_wr", F_DPY, {16'h0, DPY1_OUT, 8'h00});
        expect_v("led_unmapped_wr", F_LED, 32'h0000_A5A5);
        expect_v("dpy1_rd", F_LDATA, DPY1_RD);
        tick();
        drive(1'b0, 32'h0, MEM_LW, 32'hBFD0_0404, 32'h0);
        expect_v("unmapped_rd", F_LDATA, 32'h0);

        // window boundaries fall through to SRAM
        tick();
        drive(1'b0, 32'h0, MEM_SW, 32'hBFD0_0410, 32'h1111_2222);
        expect_v("win_end_op", F_OP, {28'h0, MEM_SW});
        expect_v("win_end_addr", F_ADDR, 32'h0004_0104);
        tick();
        drive(1'b0, 32'h0, MEM_LW, 32'hBFD0_03FC, 32'h0);
        expect_v("below_base_op", F_OP, {28'h0, MEM_LW});
        expect_v("below_base_ld", F_LDATA, ram_word(20'h400FF));
        expect_v("win_end_wcnt", F_WCNT, 32'd1);

        // fetch + load conflict
        tick();
        drive(1'b1, 32'h8000_0000, MEM_LW, 32'h8010_0010, 32'h0);
        expect_v("cf1_addr", F_ADDR, 32'h0004_0004);
        expect_v("cf1_stall", F_STALL, 32'h1);
        expect_v("cf1_ld", F_LDATA, ram_word(20'h40004));
        tick();
        expect_v("cf2_addr", F_ADDR, 32'h0);
        expect_v("cf2_stall", F_STALL, 32'h0);
        expect_v("cf2_inst", F_LINST, ram_word(20'h0));
        expect_v("cf2_ld_hold", F_LDATA, ram_word(20'h40004));
        tick();
        drive(1'b1, 32'h8000_0004, MEM_NOP, 32'h0, 32'h0);
        expect_v("fetch_addr", F_ADDR, 32'h1);
        expect_v("fetch_inst", F_LINST, ram_word(20'h1));
        expect_v("fetch_stall", F_STALL, 32'h0);

        // fetch + store conflict
        tick();
        drive(1'b1, 32'h8000_0008, MEM_SW, 32'h8000_0100, 32'hDEAD_BEEF);
        expect_v("cs1_op", F_OP, {28'h0, MEM_SW});
        expect_v("cs1_wdata", F_WDATA, 32'hDEAD_BEEF);
        expect_v("cs1_stall", F_STALL, 32'h1);
        tick();
        expect_v("cs2_op", F_OP, {28'h0, MEM_LW});
        expect_v("cs2_addr", F_ADDR, 32'h2);
        tick();
        drive(1'b0, 32'h0, MEM_NOP, 32'h0, 32'h0);
        expect_v("cs_wcnt", F_WCNT, 32'd2);

        // fetch + MMIO load is not a conflict
        tick();
        drive(1'b1, 32'h8000_000C, MEM_LW, 32'hBFD0_0400, 32'h0);
        expect_v("cm_stall", F_STALL, 32'h0);
        expect_v("cm_ld", F_LDATA, 32'h0000_A5A5);
        expect_v("cm_inst", F_LINST, ram_word(20'h3));
        expect_v("cm_addr", F_ADDR, 32'h3);

        // reset while in INST
        tick();
        drive(1'b1, 32'h8000_0010, MEM_LW, 32'h8000_0200, 32'h0);
        expect_v("ri1_stall", F_STALL, 32'h1);
        tick();
        rst_n = 1'b0;
        #1;
        expect_v("ri_stall", F_STALL, 32'h0);
        expect_v("ri_op", F_OP, {28'h0, MEM_NOP});
        expect_v("ri_led", F_LED, 32'h0);
        tick();
        #2 rst_n = 1'b1;
        expect_v("ri_idle_stall", F_STALL, 32'h1);
        expect_v("ri_idle_addr", F_ADDR, 32'h80);
        tick();
        drive(1'b0, 32'h0, MEM_NOP, 32'h0, 32'h0);
        tick();
        tick();

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d pending expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
